// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared types and helpers for the motor ramp controller.
//               The state encoding equals the portc status code. The direction
//               enum names the requested drive direction. ramp_toward()
//               performs the saturating bounded step of the duty ramp.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

  // Encoding is exported directly on portc.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FWD  = 2'b01,
    ST_REV  = 2'b10,
    ST_DEAD = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_FWD  = 2'b01,
    DIR_REV  = 2'b10
  } dir_e;

  // Last PWM count value; a period spans counts 0..PWM_MAX (255 counts).
  localparam logic [7:0] PWM_MAX = 8'd254;

  // Move cur toward tgt by at most step. The 9-bit intermediate keeps the
  // upward step from wrapping past 255. The result never overshoots tgt.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [8:0] step);
    logic [8:0] up;
    logic [8:0] gap;
    up  = {1'b0, cur} + step;
    gap = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) begin
      ramp_toward = (up > {1'b0, tgt}) ? tgt : up[7:0];
    end else begin
      ramp_toward = (gap > step) ? (cur - step[7:0]) : tgt;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_ctrl_if
// Description : Bundle of the controller's functional signals.
//   run      : 1 = regulate, 0 = soft stop
//   adc      : ADC sample (unsigned, 8 bit)
//   setpoint : DIP-switch setpoint (unsigned, 8 bit)
//   motor    : [2] bridge enable, [1] forward leg PWM, [0] reverse leg PWM
//   portc    : status 00 IDLE, 01 FWD, 10 REV, 11 DEAD
//   duty     : duty currently applied
//   The master modport drives the inputs. The slave modport is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface motor_ramp_ctrl_if;
  logic       run;
  logic [7:0] adc;
  logic [7:0] setpoint;
  logic [2:0] motor;
  logic [1:0] portc;
  logic [7:0] duty;

  modport master (
    output run, adc, setpoint,
    input  motor, portc, duty
  );

  modport slave (
    input  run, adc, setpoint,
    output motor, portc, duty
  );
endinterface
`default_nettype wire

// File: rtl/motor_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_timebase
// Description : PWM timebase. A prescaler divides clk by TICK_DIV to produce a
//               count tick. pwm_cnt advances 0..254 on each tick and then wraps
//               to 0. boundary is high for the single clk cycle that ends a
//               PWM period.
//   clk      : system clock
//   reset    : asynchronous, active-low reset
//   pwm_cnt  : current PWM count (0..254)
//   boundary : high in the last clk of a PWM period
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_timebase
  import motor_pkg::*;
#(
  parameter int TICK_DIV = 21176
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pwm_cnt,
  output logic       boundary
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic          tick;

  assign tick     = (prescaler_q == PRE_LAST);
  assign boundary = tick && (pwm_cnt_q == PWM_MAX);
  assign pwm_cnt  = pwm_cnt_q;

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    pwm_cnt_d   = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q <= '0;
      pwm_cnt_q   <= 8'd0;
    end else begin
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : motor_ramp_ctrl
// Description : Closed-loop H-bridge sequencer. It compares adc with setpoint
//               to pick a direction and a target duty. It ramps the applied
//               duty toward that target once per PWM period. A direction
//               change is forced through a ramp to zero and a dead interval
//               with the bridge disabled.
//   clk      : system clock
//   reset    : asynchronous, active-low reset (cuts the outputs at once)
//   bus      : slave side of motor_ramp_ctrl_if
//              (run, adc, setpoint in; motor, portc, duty out)
// Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int TICK_DIV     = 21176,
  parameter int RAMP_STEP    = 16,
  parameter int DEAD_PERIODS = 4,
  parameter int DEADBAND     = 4
) (
  input  logic               clk,
  input  logic               reset,
  motor_ramp_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_FWD  = ST_FWD;
  localparam logic [1:0] S_REV  = ST_REV;
  localparam logic [1:0] S_DEAD = ST_DEAD;

  localparam logic [8:0]        STEP9     = 9'(RAMP_STEP);
  localparam logic signed [8:0] DB_POS    = 9'(DEADBAND);
  localparam logic signed [8:0] DB_NEG    = -DB_POS;
  localparam int                DW        = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DW-1:0]     DEAD_LAST = DW'(DEAD_PERIODS - 1);

  logic [7:0]    pwm_cnt;
  logic          boundary;

  logic [1:0]    state_q, state_d;
  logic [7:0]    duty_q, duty_d;
  logic [DW-1:0] dead_q, dead_d;

  logic signed [8:0] err;
  logic [8:0]        abs_err;
  logic [7:0]        mag;
  dir_e              req_dir;
  logic [7:0]        target;
  logic              pwm;
  logic [2:0]        motor_w;

  motor_pwm_timebase #(
    .TICK_DIV (TICK_DIV)
  ) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .pwm_cnt  (pwm_cnt),
    .boundary (boundary)
  );

  // Error path. The inputs are only acted upon at a boundary, so these can
  // follow the inputs freely inside a period.
  assign err     = $signed({1'b0, bus.adc}) - $signed({1'b0, bus.setpoint});
  assign abs_err = err[8] ? (~err + 9'sd1) : err;
  assign mag     = abs_err[8] ? 8'hFF : abs_err[7:0];

  always_comb begin
    req_dir = DIR_NONE;
    if (bus.run) begin
      if (err > DB_POS) begin
        req_dir = DIR_FWD;
      end else if (err < DB_NEG) begin
        req_dir = DIR_REV;
      end
    end
  end

  assign target = (req_dir != DIR_NONE) ? mag : 8'd0;

  // Duty 255 exceeds every count 0..254, so that leg stays high for the
  // whole period.
  assign pwm = (pwm_cnt < duty_q);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    if (boundary) begin
      case (state_q)
        S_IDLE: begin
          duty_d = 8'd0;
          if (req_dir == DIR_FWD) begin
            state_d = S_FWD;
            duty_d  = ramp_toward(8'd0, target, STEP9);
          end else if (req_dir == DIR_REV) begin
            state_d = S_REV;
            duty_d  = ramp_toward(8'd0, target, STEP9);
          end
        end
        S_FWD: begin
          // Leave only once the ramp already sits at zero. A ramp that reaches
          // zero on this boundary leaves on the next one.
          if ((duty_q == 8'd0) && (req_dir != DIR_FWD)) begin
            state_d = S_DEAD;
            dead_d  = '0;
          end else begin
            duty_d = ramp_toward(duty_q, (req_dir == DIR_FWD) ? target : 8'd0, STEP9);
          end
        end
        S_REV: begin
          if ((duty_q == 8'd0) && (req_dir != DIR_REV)) begin
            state_d = S_DEAD;
            dead_d  = '0;
          end else begin
            duty_d = ramp_toward(duty_q, (req_dir == DIR_REV) ? target : 8'd0, STEP9);
          end
        end
        default: begin
          duty_d = 8'd0;
          if (dead_q == DEAD_LAST) begin
            state_d = S_IDLE;
          end else begin
            dead_d = dead_q + DW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      duty_q  <= 8'd0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
    end
  end

  // The outputs decode directly from the state register. An asynchronous
  // reset therefore disables the bridge in the same cycle. Each state drives
  // at most one leg.
  always_comb begin
    motor_w = 3'b000;
    case (state_q)
      S_FWD:   motor_w = {1'b1, pwm, 1'b0};
      S_REV:   motor_w = {1'b1, 1'b0, pwm};
      default: motor_w = 3'b000;
    endcase
  end

  assign bus.motor = motor_w;
  assign bus.portc = state_q;
  assign bus.duty  = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_ramp_ctrl
// Description : Scoreboard bench for motor_ramp_ctrl. For every PWM period a
//               stimulus process applies inputs and advances an integer
//               reference model. It then queues the state and duty expected
//               for the following period. A monitor samples every clk of each
//               period and compares the status, the duty and the leg high
//               times against the queued entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_ramp_ctrl;

  localparam int TICK_DIV     = 2;
  localparam int RAMP_STEP    = 64;
  localparam int DEAD_PERIODS = 2;
  localparam int DEADBAND     = 4;
  localparam int PER          = 255 * TICK_DIV;

  logic clk = 1'b0;
  logic reset;

  motor_ramp_ctrl_if bus_if ();

  motor_ramp_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .RAMP_STEP    (RAMP_STEP),
    .DEAD_PERIODS (DEAD_PERIODS),
    .DEADBAND     (DEADBAND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct { int st; int duty; } exp_t;
  typedef struct { bit run; int adc; int sp; } stim_t;

  exp_t  sb_q[$];
  stim_t plan[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 fwd, 2 rev, 3 dead.
  int m_st   = 0;
  int m_duty = 0;
  int m_dead = 0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void add_phase(bit run, int adc, int sp, int n);
    stim_t s;
    s.run = run; s.adc = adc; s.sp = sp;
    for (int i = 0; i < n; i++) plan.push_back(s);
  endfunction

  // Applies the rules for one period end to the model.
  function automatic void model_step(bit run, int adc, int sp);
    int err, dir, tgt, eff;
    err = adc - sp;
    dir = 0;
    if (run && err > DEADBAND)       dir = 1;
    else if (run && err < -DEADBAND) dir = 2;
    tgt = (dir != 0) ? ((err < 0) ? -err : err) : 0;
    if (tgt > 255) tgt = 255;
    case (m_st)
      0: if (dir != 0) begin
           m_st   = dir;
           m_duty = (tgt < RAMP_STEP) ? tgt : RAMP_STEP;
         end
      1, 2: begin
        if (m_duty == 0 && dir != m_st) begin
          m_st   = 3;
          m_dead = 0;
        end else begin
          eff = (dir == m_st) ? tgt : 0;
          if (m_duty < eff) m_duty = (m_duty + RAMP_STEP > eff) ? eff : m_duty + RAMP_STEP;
          else              m_duty = (m_duty - RAMP_STEP < eff) ? eff : m_duty - RAMP_STEP;
        end
      end
      default: begin
        m_duty = 0;
        if (m_dead >= DEAD_PERIODS - 1) m_st = 0;
        else m_dead++;
      end
    endcase
  endfunction

  task automatic stim();
    exp_t e;
    e.st = m_st; e.duty = m_duty;
    sb_q.push_back(e);
    foreach (plan[i]) begin
      bus_if.run      = plan[i].run;
      bus_if.adc      = 8'(plan[i].adc);
      bus_if.setpoint = 8'(plan[i].sp);
      model_step(plan[i].run, plan[i].adc, plan[i].sp);
      e.st = m_st; e.duty = m_duty;
      sb_q.push_back(e);
      repeat (PER) @(negedge clk);
    end
  endtask

  task automatic mon(int nper);
    for (int p = 0; p < nper; p++) begin
      exp_t e;
      int en_c = 0, f_c = 0, r_c = 0, both = 0, pc_bad = 0, du_bad = 0;
      int exp_en, exp_f, exp_r;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p%0d_scoreboard actual=empty required=entry", p);
        e.st = 0; e.duty = 0;
      end else begin
        e = sb_q.pop_front();
      end
      for (int i = 0; i < PER; i++) begin
        if (bus_if.motor[2]) en_c++;
        if (bus_if.motor[1]) f_c++;
        if (bus_if.motor[0]) r_c++;
        if (bus_if.motor[1] && bus_if.motor[0]) both++;
        if (int'(bus_if.portc) != e.st)  pc_bad++;
        if (int'(bus_if.duty) != e.duty) du_bad++;
        @(negedge clk);
      end
      exp_en = (e.st == 1 || e.st == 2) ? PER : 0;
      exp_f  = (e.st == 1) ? 2 * e.duty : 0;
      exp_r  = (e.st == 2) ? 2 * e.duty : 0;
      check($sformatf("p%0d_portc_st%0d_bad_samples", p, e.st), pc_bad, 0);
      check($sformatf("p%0d_duty%0d_bad_samples", p, e.duty), du_bad, 0);
      check($sformatf("p%0d_enable_cycles", p), en_c, exp_en);
      check($sformatf("p%0d_fwd_high_cycles", p), f_c, exp_f);
      check($sformatf("p%0d_rev_high_cycles", p), r_c, exp_r);
      check($sformatf("p%0d_both_legs_high", p), both, 0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nseg;
    reset           = 1'b1;
    bus_if.run      = 1'b1;
    bus_if.adc      = 8'd200;
    bus_if.setpoint = 8'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_motor", int'(bus_if.motor), 0);
    check("reset_portc", int'(bus_if.portc), 0);
    check("reset_duty",  int'(bus_if.duty),  0);

    // Directed phases: forward ramp, reversal, deadband, saturation, soft stop.
    add_phase(1, 200, 0,   5);
    add_phase(1, 0,   100, 10);
    add_phase(1, 102, 100, 8);
    add_phase(1, 255, 0,   7);
    add_phase(1, 128, 0,   6);
    add_phase(0, 128, 0,   6);
    // Random segments with inputs held for a few periods each.
    nseg = 14;
    for (int s = 0; s < nseg; s++) begin
      int sp, ad, len;
      bit rn;
      sp  = int'($urandom_range(255, 0));
      if ($urandom_range(3, 0) == 0) begin
        ad = sp + int'($urandom_range(12, 0)) - 6;
        if (ad < 0) ad = 0;
        if (ad > 255) ad = 255;
      end else begin
        ad = int'($urandom_range(255, 0));
      end
      rn  = ($urandom_range(4, 0) != 0);
      len = int'($urandom_range(6, 1));
      add_phase(rn, ad, sp, len);
    end
    // Finish in reverse drive for the mid-run reset.
    add_phase(1, 0, 200, 12);

    @(negedge clk);
    reset = 1'b1;
    fork
      stim();
      mon(plan.size());
    join

    // Mid-period inside the final period, then reset between clock edges.
    repeat (100) @(negedge clk);
    check("midrun_enable_before_reset", int'(bus_if.motor[2]), (m_st == 1 || m_st == 2) ? 1 : 0);
    check("midrun_portc_before_reset", int'(bus_if.portc), m_st);
    #2 reset = 1'b0;
    #1;
    check("midrun_reset_motor", int'(bus_if.motor), 0);
    check("midrun_reset_portc", int'(bus_if.portc), 0);
    check("midrun_reset_duty",  int'(bus_if.duty),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
